// File: rtl/match_controller_if.sv
// Bundles the keyboard, collision and display-side signals of the match controller.
// The slave modport is the controller; the master modport is its environment.
interface match_controller_if #(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_MAPS      = 2,
    parameter int WINS_TO_MATCH = 3
);
    localparam int PID_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int MAP_W   = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
    localparam int SCORE_W = $clog2(WINS_TO_MATCH + 1);
    localparam int BG_W    = $clog2(NUM_MAPS + NUM_PLAYERS + 1);

    logic [7:0]                     keycode;
    logic                           round_over;
    logic                           winner_valid;
    logic [PID_W-1:0]               winner_id;
    logic [2:0]                     game_state;
    logic [MAP_W-1:0]               map_select;
    logic [BG_W-1:0]                background_select;
    logic                           load_background;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic [PID_W-1:0]               match_winner;

    modport master (
        output keycode, round_over, winner_valid, winner_id,
        input  game_state, map_select, background_select, load_background, scores, match_winner
    );

    modport slave (
        input  keycode, round_over, winner_valid, winner_id,
        output game_state, map_select, background_select, load_background, scores, match_winner
    );
endinterface

// File: rtl/match_controller.sv
// Game-flow controller for N-player light-cycle matches: menu, map choice, rounds,
// timed result display and best-of-N scoring, driven by edge-detected key presses.
module match_controller #(
    parameter int         NUM_PLAYERS   = 2,
    parameter int         NUM_MAPS      = 2,
    parameter int         WINS_TO_MATCH = 3,
    parameter int         RESULT_CYCLES = 50_000_000,
    parameter logic [7:0] KEY_ENTER     = 8'h28,
    parameter logic [7:0] KEY_UP        = 8'h52,
    parameter logic [7:0] KEY_DOWN      = 8'h51,
    parameter logic [7:0] KEY_PAUSE     = 8'h29
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_reset_game,
    match_controller_if.slave   io_bus
);
    localparam int PID_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int MAP_W   = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;
    localparam int SCORE_W = $clog2(WINS_TO_MATCH + 1);
    localparam int BG_W    = $clog2(NUM_MAPS + NUM_PLAYERS + 1);
    localparam int CNT_W   = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

    localparam logic [MAP_W-1:0]   MAP_LAST  = MAP_W'(NUM_MAPS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(WINS_TO_MATCH);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(RESULT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_MENU          = 3'd0,
        ST_ROUND_PAUSED  = 3'd1,
        ST_ROUND_STARTED = 3'd2,
        ST_ROUND_RESULT  = 3'd3,
        ST_MATCH_WIN     = 3'd4
    } state_t;

    state_t               r_state;
    logic [7:0]           r_prev_key;
    logic [MAP_W-1:0]     r_map;
    logic [SCORE_W-1:0]   r_scores [NUM_PLAYERS];
    logic [PID_W-1:0]     r_match_winner;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_load_arm;
    logic                 r_load;

    logic                 w_new_key;
    logic                 w_press_enter;
    logic                 w_press_up;
    logic                 w_press_down;
    logic                 w_press_pause;
    logic                 w_valid_win;
    logic                 w_any_match;
    logic [PID_W-1:0]     w_match_idx;
    logic                 w_leave_result;

    assign w_new_key     = (io_bus.keycode != r_prev_key);
    assign w_press_enter = w_new_key && (io_bus.keycode == KEY_ENTER);
    assign w_press_up    = w_new_key && (io_bus.keycode == KEY_UP);
    assign w_press_down  = w_new_key && (io_bus.keycode == KEY_DOWN);
    assign w_press_pause = w_new_key && (io_bus.keycode == KEY_PAUSE);

    // Out-of-range winner ids count as a draw.
    assign w_valid_win = io_bus.round_over && io_bus.winner_valid &&
                         ({1'b0, io_bus.winner_id} < (PID_W + 1)'(NUM_PLAYERS));

    assign w_leave_result = (r_cnt == CNT_LAST) || w_press_enter;

    // Descending scan so the lowest-indexed player at the target score wins ties.
    always_comb begin
        w_any_match = 1'b0;
        w_match_idx = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (r_scores[p] == SCORE_MAX) begin
                w_any_match = 1'b1;
                w_match_idx = PID_W'(p);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_MENU;
            r_prev_key     <= 8'h00;
            r_map          <= '0;
            r_match_winner <= '0;
            r_cnt          <= '0;
            r_load_arm     <= 1'b0;
            r_load         <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= '0;
        end else begin
            r_prev_key <= io_bus.keycode;
            r_load     <= r_load_arm;
            r_load_arm <= 1'b0;
            if (i_reset_game) begin
                r_state        <= ST_MENU;
                r_match_winner <= '0;
                r_cnt          <= '0;
                r_load         <= 1'b0;
                for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= '0;
            end else begin
                case (r_state)
                    ST_MENU: begin
                        if (w_press_enter) begin
                            r_state    <= ST_ROUND_PAUSED;
                            r_load_arm <= 1'b1;
                        end else if (w_press_up) begin
                            r_map <= (r_map == MAP_LAST) ? '0 : r_map + MAP_W'(1);
                        end else if (w_press_down) begin
                            r_map <= (r_map == '0) ? MAP_LAST : r_map - MAP_W'(1);
                        end
                    end
                    ST_ROUND_PAUSED: begin
                        if (w_press_enter) r_state <= ST_ROUND_STARTED;
                    end
                    ST_ROUND_STARTED: begin
                        if (io_bus.round_over) begin
                            for (int p = 0; p < NUM_PLAYERS; p++) begin
                                if (w_valid_win && io_bus.winner_id == PID_W'(p) &&
                                    r_scores[p] != SCORE_MAX)
                                    r_scores[p] <= r_scores[p] + SCORE_W'(1);
                            end
                            r_state <= ST_ROUND_RESULT;
                            r_cnt   <= '0;
                        end else if (w_press_pause) begin
                            r_state <= ST_ROUND_PAUSED;
                        end
                    end
                    ST_ROUND_RESULT: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_leave_result) begin
                            r_load_arm <= 1'b1;
                            if (w_any_match) begin
                                r_state        <= ST_MATCH_WIN;
                                r_match_winner <= w_match_idx;
                            end else begin
                                r_state <= ST_ROUND_PAUSED;
                            end
                        end
                    end
                    ST_MATCH_WIN: begin
                        if (w_press_enter) begin
                            r_state    <= ST_MENU;
                            r_load_arm <= 1'b1;
                            for (int p = 0; p < NUM_PLAYERS; p++) r_scores[p] <= '0;
                        end
                    end
                    default: r_state <= ST_MENU;
                endcase
            end
        end
    end

    // Background index space: maps first, then one winner screen per player, then the menu.
    always_comb begin
        case (r_state)
            ST_MENU:      io_bus.background_select = BG_W'(NUM_MAPS + NUM_PLAYERS);
            ST_MATCH_WIN: io_bus.background_select = BG_W'(NUM_MAPS) + BG_W'(r_match_winner);
            default:      io_bus.background_select = BG_W'(r_map);
        endcase
    end

    assign io_bus.game_state      = r_state;
    assign io_bus.map_select      = r_map;
    assign io_bus.load_background = r_load;
    assign io_bus.match_winner    = r_match_winner;

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_scores
        assign io_bus.scores[gi*SCORE_W +: SCORE_W] = r_scores[gi];
    end
endmodule
